// File: rtl/seq_scan_controller.sv
// Frame sequencer for a Moore "1011" detector.
// It takes one word at a time over valid/ready and shifts it MSB-first into the detector.
// It counts the detector's match pulses and returns one result per frame over valid/ready.
module seq_scan_controller #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned POS_W  = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [POS_W:0]    in_len,
  output logic              det_seq_in,
  output logic              det_reset,
  input  logic              det_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  match_count,
  output logic [POS_W-1:0]  first_pos,
  output logic              any_match
);

  localparam int unsigned LEN_W = POS_W + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [POS_W-1:0]    last_q, last_d;
  logic [POS_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [POS_W-1:0]    first_q, first_d;
  logic                any_q, any_d;
  logic                seq_q, seq_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                det_reset_q, det_reset_d;
  logic [LEN_W-1:0]    eff_len;
  logic                hit;
  logic [POS_W-1:0]    hit_idx;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    last_d   = last_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    any_d    = any_q;
    seq_d    = 1'b0;
    hit      = 1'b0;
    hit_idx  = '0;
    eff_len  = ((in_len == '0) || (in_len > LEN_W'(WORD_W))) ? LEN_W'(WORD_W) : in_len;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // shreg keeps the bits still to be sent, MSB-aligned; the first bit leaves now
          shreg_d = in_word << 1;
          seq_d   = in_word[WORD_W-1];
          last_d  = POS_W'(eff_len - LEN_W'(1));
          idx_d   = '0;
          cnt_d   = '0;
          first_d = '1;
          any_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // detector output lags its input by one cycle, so scan index 0 has nothing to report yet
        if (idx_q != '0) begin
          hit     = det_out;
          hit_idx = POS_W'(idx_q - POS_W'(1));
        end
        shreg_d = shreg_q << 1;
        idx_d   = POS_W'(idx_q + POS_W'(1));
        if (idx_q == last_q) begin
          state_d = DRAIN;
        end else begin
          seq_d = shreg_q[WORD_W-1];
        end
      end
      DRAIN: begin
        hit     = det_out;
        hit_idx = last_q;
        state_d = REPORT;
      end
      REPORT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (hit) begin
      if (cnt_q != '1) cnt_d = CNT_W'(cnt_q + CNT_W'(1));
      if (!any_q) first_d = hit_idx;
      any_d = 1'b1;
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == REPORT);
    det_reset_d = (state_d == IDLE) || (state_d == REPORT);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      last_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      first_q     <= '1;
      any_q       <= 1'b0;
      seq_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      det_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      any_q       <= any_d;
      seq_q       <= seq_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      det_reset_q <= det_reset_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign det_reset   = det_reset_q;
  assign det_seq_in  = seq_q;
  assign match_count = cnt_q;
  assign first_pos   = first_q;
  assign any_match   = any_q;

endmodule

// File: doc/seq_scan_controller.md
Name: seq_scan_controller

Overview:
Frame sequencer for the Moore "1011" sequence detector.
- Accepts parallel words over a valid/ready handshake.
- Serialises each word MSB-first into the detector's sequence_in, holding the detector in reset between frames.
- Counts detector_out pulses (overlapping matches included) and records the bit position of the first match.
- Returns one result per frame over a second valid/ready handshake.
- Sits between a word source and one detector instance; the detector has no enable and consumes one bit every clock.

Parameters:
WORD_W, 8, bits per input word (>=2).
POS_W, 3, width of bit-position fields; ceil(log2(WORD_W)).
CNT_W, 4, width of match counter; saturating.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low; reset==0 at a rising edge initialises the block.
in_valid  in  1  source presents a word.
in_ready  out  1  block can accept a word.
in_word  in  WORD_W  word to scan; bit WORD_W-1 is shifted first.
in_len  in  POS_W+1  number of bits to scan, counted from MSB; 0 or >WORD_W means WORD_W.
det_seq_in  out  1  to detector sequence_in.
det_reset  out  1  to detector reset (active-high).
det_out  in  1  from detector detector_out.
out_valid  out  1  result available.
out_ready  in  1  sink accepts result.
match_count  out  CNT_W  matches in frame.
first_pos  out  POS_W  scan index (0 = first bit shifted) of bit completing first match; all-ones if none.
any_match  out  1  match_count != 0.

Behaviour:
- States: IDLE, SHIFT, DRAIN, REPORT.
- Reset (reset==0 at edge):
  - State IDLE.
  - in_ready=1, out_valid=0, match_count=0, first_pos=all-ones, any_match=0, det_seq_in=0.
  - Works from any state, mid-frame included; any partial frame is discarded with no result.
- det_reset=1 in IDLE and REPORT, 0 in SHIFT and DRAIN. This keeps the detector in state Zero between frames, so no history carries across words.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch word into a shift register, latch effective length L (1..WORD_W), clear counters and index, go to SHIFT.
- SHIFT lasts exactly L cycles, with scan index k=0..L-1:
  - det_seq_in = latched bit WORD_W-1-k.
  - in_ready=0.
  - After cycle L-1, go to DRAIN.
- Detector timing: det_out is a function of detector state. In cycle c it reflects bits up to cycle c-1.
  - Sample det_out in SHIFT cycles k>=1 (attributed to index k-1) and in DRAIN (attributed to index L-1).
  - Ignore det_out in SHIFT k=0.
- DRAIN lasts 1 cycle, det_seq_in=0, then go to REPORT.
- On each attributed det_out==1:
  - match_count increments, saturating at 2^CNT_W-1.
  - If no earlier match in this frame, first_pos = attributed index.
- REPORT:
  - out_valid=1; match_count, first_pos and any_match are stable and held until out_valid&&out_ready.
  - On that handshake, go to IDLE and deassert out_valid the next cycle. Result fields keep their values until the next accept.
  - in_ready=0 throughout.
- Latency: word accepted at edge E; SHIFT occupies cycles E+1..E+L; DRAIN E+L+1; out_valid first high in cycle E+L+2.
- Maximum throughput is one word per L+3 cycles, with out_ready tied high.
- in_valid while not in IDLE is ignored; the source must hold the word.
- in_word and in_len are sampled only at accept.
- Result outputs are registered, not combinational.

Test Plan:
- Reset then in_word=8'b1011_0110, in_len=0, out_ready=1 -> out_valid in cycle E+10; match_count=2, first_pos=3, any_match=1; det_reset low only in cycles E+1..E+9.
- in_word=8'b0000_1011 -> match on the last bit is caught in DRAIN: match_count=1, first_pos=7.
- in_word=8'hFF, then 8'b1011_1011 back-to-back with in_valid held -> first result count=0, first_pos=7'h7 (all-ones, 3'b111); second result count=2, first_pos=3. The second frame must not inherit state from the first.
- in_word=8'hB0, in_len=4 -> SHIFT lasts 4 cycles, out_valid at E+6, count=1, first_pos=3. in_len=9 behaves as 8.
- out_ready held low for 5 cycles in REPORT -> out_valid and fields stable, in_ready=0, in_valid ignored. Release -> IDLE, next word accepted.
- reset=0 during SHIFT cycle k=2 -> next cycle IDLE, det_reset=1, out_valid=0, in_ready=1, no result emitted. A following frame (8'b1011_0110) gives count=2.
